// File: rtl/drive_volume_requester.sv
// Block-request sequencer: validates a read/write command against the volume state,
// then runs a strobe/ack request-release handshake with the storage side, with an optional timeout.
//   state   | meaning
//   IDLE    | waiting for a command (cmd_ready while vol_ack is low)
//   REQ     | vol_rd/vol_wr held until vol_ack is seen high
//   RELEASE | strobe dropped, waiting for vol_ack to fall
//   DONE    | one-cycle done pulse with the final status
module drive_volume_requester #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  input  logic        cmd_write,
  input  logic [31:0] cmd_lba,
  input  logic [5:0]  cmd_blk_cnt,
  output logic        cmd_ready,
  output logic        busy,
  output logic        done,
  output logic [2:0]  status,
  input  logic        vol_ready,
  input  logic        vol_mounted,
  input  logic        vol_readonly,
  input  logic [31:0] vol_size,
  input  logic        vol_ack,
  output logic        vol_active,
  output logic [31:0] vol_lba,
  output logic [5:0]  vol_blk_cnt,
  output logic        vol_rd,
  output logic        vol_wr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RELEASE, S_DONE} state_e;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_NOTREADY = 3'd1;
  localparam logic [2:0] ST_NOTMOUNT = 3'd2;
  localparam logic [2:0] ST_READONLY = 3'd3;
  localparam logic [2:0] ST_RANGE    = 3'd4;
  localparam logic [2:0] ST_TIMEOUT  = 3'd5;

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  status_q, status_d;
  logic        active_q, active_d;
  logic [31:0] lba_q, lba_d;
  logic [5:0]  blk_q, blk_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [23:0] tmo_q, tmo_d;

  logic        accept;
  logic        timeout_hit;
  logic [32:0] end_blk;
  logic [2:0]  check_code;

  assign cmd_ready = (state_q == S_IDLE) && !vol_ack;

  always_comb begin
    accept      = cmd_valid && cmd_ready;
    // 33-bit sum so an LBA near 2^32 cannot wrap past the size check
    end_blk     = {1'b0, cmd_lba} + {27'b0, cmd_blk_cnt};
    timeout_hit = (TIMEOUT_CYCLES != 24'd0) && ((tmo_q + 24'd1) == TIMEOUT_CYCLES);

    if (!vol_ready)                                          check_code = ST_NOTREADY;
    else if (!vol_mounted)                                   check_code = ST_NOTMOUNT;
    else if (cmd_write && vol_readonly)                      check_code = ST_READONLY;
    else if (cmd_blk_cnt == 6'd0 || end_blk > {1'b0, vol_size}) check_code = ST_RANGE;
    else                                                     check_code = ST_OK;

    state_d  = state_q;
    done_d   = 1'b0;
    status_d = status_q;
    active_d = active_q;
    lba_d    = lba_q;
    blk_d    = blk_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    tmo_d    = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          lba_d = cmd_lba;
          blk_d = cmd_blk_cnt;
          tmo_d = 24'd0;
          if (check_code != ST_OK) begin
            state_d  = S_DONE;
            status_d = check_code;
            done_d   = 1'b1;
          end else begin
            state_d  = S_REQ;
            status_d = ST_OK;
            active_d = 1'b1;
            rd_d     = !cmd_write;
            wr_d     = cmd_write;
          end
        end
      end
      S_REQ, S_RELEASE: begin
        tmo_d = tmo_q + 24'd1;
        // timeout wins over an ack edge seen on the same cycle
        if (timeout_hit) begin
          state_d  = S_DONE;
          status_d = ST_TIMEOUT;
          done_d   = 1'b1;
          active_d = 1'b0;
          rd_d     = 1'b0;
          wr_d     = 1'b0;
        end else if (state_q == S_REQ) begin
          if (vol_ack) begin
            state_d = S_RELEASE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
          end
        end else if (!vol_ack) begin
          state_d  = S_DONE;
          status_d = ST_OK;
          done_d   = 1'b1;
          active_d = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= 3'd0;
      active_q <= 1'b0;
      lba_q    <= 32'd0;
      blk_q    <= 6'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      tmo_q    <= 24'd0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      status_q <= status_d;
      active_q <= active_d;
      lba_q    <= lba_d;
      blk_q    <= blk_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      tmo_q    <= tmo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign status      = status_q;
  assign vol_active  = active_q;
  assign vol_lba     = lba_q;
  assign vol_blk_cnt = blk_q;
  assign vol_rd      = rd_q;
  assign vol_wr      = wr_q;

endmodule
